// File: rtl/regfile_ctx_mover_pkg.sv
// Shared definitions for the interrupt context save/restore engine:
// state encodings, transfer mode constants and default memory layout.
package regfile_ctx_mover_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } ctx_state_e;

  localparam logic CTX_SAVE    = 1'b0;
  localparam logic CTX_RESTORE = 1'b1;

  localparam int unsigned CTX_DEFAULT_STRIDE = 4;
  localparam logic [31:0] CTX_DEFAULT_BASE   = 32'h0000_0100;

  // Byte address of the slot holding register idx; wraps modulo 2^32.
  function automatic logic [31:0] ctx_slot_addr(input logic [31:0] base,
                                                input logic [4:0]  idx,
                                                input logic [4:0]  first,
                                                input logic [31:0] stride);
    logic [4:0] slot;
    slot = idx - first;
    return base + ({27'd0, slot} * stride);
  endfunction

endpackage

// File: rtl/regfile_ctx_mover.sv
// Moves the register window x[FIRST_REG..LAST_REG] between the integer regfile
// and memory, one beat per accepted memory request, on trap entry or mret.
module regfile_ctx_mover
  import regfile_ctx_mover_pkg::*;
#(
  parameter int unsigned FIRST_REG   = 1,
  parameter int unsigned LAST_REG    = 31,
  parameter int unsigned ADDR_STRIDE = CTX_DEFAULT_STRIDE
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] base,
  output logic        busy,
  output logic        done,
  output logic [4:0]  rf_rn,
  input  logic [31:0] rf_q,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d,
  output logic        rf_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [4:0]  FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0]  LAST_IDX  = 5'(LAST_REG);
  localparam logic [31:0] STRIDE    = 32'(ADDR_STRIDE);

  ctx_state_e  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] base_q, base_d;

  logic in_save;
  logic in_restore;
  logic in_xfer;
  logic [31:0] slot_addr;

  assign in_save    = (state_q == ST_SAVE);
  assign in_restore = (state_q == ST_RESTORE);
  assign in_xfer    = in_save | in_restore;
  assign slot_addr  = ctx_slot_addr(base_q, idx_q, FIRST_IDX, STRIDE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base;
          idx_d   = FIRST_IDX;
          state_d = (mode == CTX_RESTORE) ? ST_RESTORE : ST_SAVE;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        // A beat retires only when memory accepts it; otherwise everything holds.
        if (mem_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      idx_q   <= 5'd0;
      base_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  // Data paths are combinational so each beat completes in the cycle it is accepted.
  assign busy      = in_xfer;
  assign done      = (state_q == ST_DONE);
  assign mem_req   = in_xfer;
  assign mem_we    = in_save;
  assign mem_addr  = in_xfer ? slot_addr : 32'd0;
  assign mem_wdata = in_save ? rf_q : 32'd0;
  assign rf_rn     = in_save ? idx_q : 5'd0;
  assign rf_wn     = in_restore ? idx_q : 5'd0;
  assign rf_d      = in_restore ? mem_rdata : 32'd0;
  assign rf_we     = in_restore & mem_ready;

endmodule

// File: tb/tb_regfile_ctx_mover.sv
// Randomised bench for regfile_ctx_mover: a behavioural regfile/memory model
// predicts every beat, the done timing and the final register contents.
module tb_regfile_ctx_mover;
  import regfile_ctx_mover_pkg::*;

  localparam int FIRST = 1;
  localparam int LAST  = 31;
  localparam int N     = LAST - FIRST + 1;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic        mode;
  logic [31:0] base;
  logic        busy, done;
  logic [4:0]  rf_rn, rf_wn;
  logic [31:0] rf_q, rf_d;
  logic        rf_we;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  logic [31:0] rf     [32];
  logic [31:0] ref_rf [32];
  bit          preload = 1'b0;
  logic [31:0] pat_key = 32'd0;

  always #5 clk = ~clk;

  regfile_ctx_mover #(
    .FIRST_REG  (FIRST),
    .LAST_REG   (LAST),
    .ADDR_STRIDE(4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .mode     (mode),
    .base     (base),
    .busy     (busy),
    .done     (done),
    .rf_rn    (rf_rn),
    .rf_q     (rf_q),
    .rf_wn    (rf_wn),
    .rf_d     (rf_d),
    .rf_we    (rf_we),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  // Regfile: x0 reads zero; preload copies the model state in.
  assign rf_q = (rf_rn == 5'd0) ? 32'd0 : rf[rf_rn];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= ref_rf[i];
    end else if (rf_we && rf_wn != 5'd0) begin
      rf[rf_wn] <= rf_d;
    end
  end

  // Memory contents are a fixed function of address.
  function automatic logic [31:0] pat(input logic [31:0] a);
    if (pat_key == 32'd0) return 32'h0000_A000 + ((a - 32'h200) >> 2);
    return a ^ pat_key;
  endfunction
  assign mem_rdata = pat(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_regs(input bit stepped);
    for (int i = 0; i < 32; i++) ref_rf[i] = stepped ? 32'(i * 32'h11) : $urandom;
    ref_rf[0] = 32'd0;
    #1 preload = 1'b1;
    @(posedge clk);
    #1 preload = 1'b0;
  endtask

  task automatic compare_regs();
    for (int i = 1; i < 32; i++) check("rf_contents", rf[i], ref_rf[i]);
  endtask

  // rmode: 0 ready always, 1 ready on every 3rd cycle, 2 random ready.
  task automatic run_xfer(input logic md, input logic [31:0] b, input int rmode,
                          input bit glitch, input int exp_done);
    int beats = 0;
    int last_c = 0;
    int done_cnt = 0;
    int done_at = 0;
    bit p_stall = 1'b0;
    logic [31:0] p_addr = 32'd0, p_wdata = 32'd0, addr_e;
    logic [4:0]  p_rn = 5'd0;
    #1;
    start = 1'b1; mode = md; base = b; mem_ready = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      #1;
      start = glitch && (c == 5 || c == exp_done);
      mode  = 1'($urandom_range(0, 1));
      base  = $urandom;
      case (rmode)
        0:       mem_ready = 1'b1;
        1:       mem_ready = (c % 3 == 2);
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      check("busy", busy, 32'(beats < N));
      check("done", done, 32'(beats == N && c == last_c + 1));
      check("rf_we", rf_we, 32'(md && beats < N && mem_ready));
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = c;
      end
      if (beats < N) begin
        addr_e = b + 32'(beats) * 32'd4;
        check("mem_req", mem_req, 32'd1);
        check("mem_we", mem_we, 32'(!md));
        check("mem_addr", mem_addr, addr_e);
        if (md == CTX_SAVE) begin
          check("mem_wdata", mem_wdata, ref_rf[FIRST + beats]);
          check("rf_rn", rf_rn, 32'(FIRST + beats));
          if (p_stall) begin
            check("stall_addr", mem_addr, p_addr);
            check("stall_wdata", mem_wdata, p_wdata);
            check("stall_rn", rf_rn, 32'(p_rn));
          end
        end else begin
          check("rf_wn", rf_wn, 32'(FIRST + beats));
          check("rf_d", rf_d, pat(addr_e));
        end
        p_stall = !mem_ready;
        p_addr = mem_addr; p_wdata = mem_wdata; p_rn = rf_rn;
        if (mem_ready) begin
          if (md == CTX_RESTORE) ref_rf[FIRST + beats] = pat(addr_e);
          beats++;
          last_c = c;
        end
      end else begin
        check("mem_req_idle", mem_req, 32'd0);
        p_stall = 1'b0;
      end
      @(posedge clk);
      if (beats == N && c >= last_c + 3) break;
    end
    start = 1'b0;
    check("beat_count", 32'(beats), 32'(N));
    check("done_count", 32'(done_cnt), 32'd1);
    if (exp_done != 0) check("done_cycle", 32'(done_at), 32'(exp_done));
    $display("xfer mode=%0d base=%h ready_mode=%0d beats=%0d done_cycle=%0d",
             md, b, rmode, beats, done_at);
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; mode = 1'b0; base = 32'd0; mem_ready = 1'b0;
    load_regs(1'b1);
    @(negedge clk);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_req_we", {mem_req, mem_we, rf_we}, 32'd0);
    check("rst_wide", 32'(|{mem_addr, mem_wdata, rf_d, rf_rn, rf_wn}), 32'd0);
    @(posedge clk);
    #1 clr = 1'b0;

    // Save of x1..x31 = i*0x11 to 0x100
    run_xfer(CTX_SAVE, 32'h100, 0, 1'b0, 32);
    // Restore from 0x200 where mem = 0xA000+k
    pat_key = 32'd0;
    run_xfer(CTX_RESTORE, 32'h200, 0, 1'b0, 32);
    compare_regs();
    // Stalled save, ready every third cycle
    load_regs(1'b0);
    run_xfer(CTX_SAVE, 32'h0000_4000, 1, 1'b0, 93);
    // Address wraps through zero
    run_xfer(CTX_SAVE, 32'hFFFF_FFF8, 0, 1'b0, 32);
    // Starts inside SAVE and DONE are ignored
    run_xfer(CTX_SAVE, 32'h300, 0, 1'b1, 32);
    // Randomised restores and saves
    for (int t = 0; t < 3; t++) begin
      pat_key = $urandom | 32'd1;
      run_xfer(CTX_RESTORE, $urandom & 32'hFFFF_FFFC, 2, 1'b0, 0);
      compare_regs();
      run_xfer(CTX_SAVE, $urandom, 2, 1'b0, 0);
    end

    // Abort a restore after ten beats
    pat_key = $urandom | 32'd1;
    #1;
    start = 1'b1; mode = CTX_RESTORE; base = 32'h800;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      #1 start = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      check("abort_rf_wn", rf_wn, 32'(c));
      ref_rf[c] = pat(32'h800 + 32'(c - 1) * 32'd4);
      @(posedge clk);
    end
    #1 clr = 1'b1;
    #1;
    check("abort_busy", busy, 32'd0);
    check("abort_req_we", {mem_req, mem_we, rf_we}, 32'd0);
    check("abort_wide", 32'(|{mem_addr, mem_wdata, rf_d, rf_rn, rf_wn}), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_done", done, 32'd0);
    end
    @(posedge clk);
    #1 clr = 1'b0;
    compare_regs();
    $display("xfer abort after 10 restore beats");
    run_xfer(CTX_RESTORE, 32'h900, 0, 1'b0, 32);
    compare_regs();
    run_xfer(CTX_SAVE, 32'hA00, 2, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
